exc_commit_ctrl: RTL and testbench



---
 rtl/exc_commit_ctrl_pkg.sv | 36 +++
 rtl/exc_commit_ctrl_prio.sv | 23 ++
 rtl/exc_commit_ctrl.sv | 133 +++++++++++++
 tb/tb_exc_commit_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/exc_commit_ctrl_pkg.sv
// Shared CSR definitions: CSR numbers, exception codes and commit-controller encodings.
package exc_commit_ctrl_pkg;

    localparam logic [8:0] CSR_CRMD   = 9'h000;
    localparam logic [8:0] CSR_PRMD   = 9'h001;
    localparam logic [8:0] CSR_ECFG   = 9'h004;
    localparam logic [8:0] CSR_ESTAT  = 9'h005;
    localparam logic [8:0] CSR_ERA    = 9'h006;
    localparam logic [8:0] CSR_BADV   = 9'h007;
    localparam logic [8:0] CSR_EENTRY = 9'h00c;
    localparam logic [8:0] CSR_SAVE0  = 9'h030;

    localparam logic [5:0] ECODE_INTERRUPT = 6'h00;
    localparam logic [5:0] ECODE_ADE       = 6'h08;
    localparam logic [5:0] ECODE_ALE       = 6'h09;
    localparam logic [5:0] ECODE_SYS       = 6'h0b;
    localparam logic [5:0] ECODE_BRK       = 6'h0c;
    localparam logic [5:0] ECODE_INE       = 6'h0d;

    localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
    localparam logic [8:0] ESUBCODE_ADEM = 9'h001;

    typedef enum logic {
        ST_IDLE,
        ST_BLANK
    } commit_state_e;

    typedef enum logic [2:0] {
        EVT_NONE,
        EVT_INT,
        EVT_EXC,
        EVT_ERTN,
        EVT_CSRW
    } commit_evt_e;

endpackage

// File: rtl/exc_commit_ctrl_prio.sv
// Picks the single commit event for the WB instruction: interrupt > exception > ertn > CSR write.
module commit_prio_enc
    import exc_commit_ctrl_pkg::*;
(
    input  logic        valid_i,
    input  logic        int_pend_i,
    input  logic        ex_i,
    input  logic        ertn_i,
    input  logic        csr_we_i,
    output commit_evt_e evt_o
);

    always_comb begin
        evt_o = EVT_NONE;
        if (valid_i) begin
            if (int_pend_i)    evt_o = EVT_INT;
            else if (ex_i)     evt_o = EVT_EXC;
            else if (ertn_i)   evt_o = EVT_ERTN;
            else if (csr_we_i) evt_o = EVT_CSRW;
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Exception/interrupt commit controller: turns the WB instruction into CSR updates,
// a pipeline flush with redirect target, and a fixed-length post-flush blanking window.
module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter logic [5:0]  ECODE_INT    = ECODE_INTERRUPT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        wb_ertn,
    input  logic        wb_csr_we,
    input  logic [8:0]  wb_csr_num,
    input  logic [31:0] wb_csr_wmask,
    input  logic [31:0] wb_csr_wvalue,
    input  logic        csr_crmd_ie,
    input  logic [12:0] csr_ecfg_lie,
    input  logic [12:0] csr_estat_is,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    output logic        csr_ex,
    output logic [5:0]  csr_ecode,
    output logic [8:0]  csr_esubcode,
    output logic [31:0] csr_pc,
    output logic [31:0] csr_vaddr,
    output logic        csr_ertn_flush,
    output logic        csr_we,
    output logic [8:0]  csr_num,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        flush,
    output logic [31:0] flush_target,
    output logic        busy
);

    localparam logic [3:0] BLANK_INIT = 4'(FLUSH_CYCLES - 1);

    commit_state_e state_q, state_d;
    logic [3:0]    blank_cnt_q, blank_cnt_d;
    logic          int_pend_q;
    commit_evt_e   evt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            blank_cnt_q <= '0;
            int_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
            int_pend_q  <= csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));
        end
    end

    // Reset and BLANK both mask the WB instruction before it reaches the encoder.
    commit_prio_enc u_prio (
        .valid_i    (wb_valid & ~reset & (state_q == ST_IDLE)),
        .int_pend_i (int_pend_q),
        .ex_i       (wb_ex),
        .ertn_i     (wb_ertn),
        .csr_we_i   (wb_csr_we),
        .evt_o      (evt)
    );

    always_comb begin
        state_d        = state_q;
        blank_cnt_d    = blank_cnt_q;
        csr_ex         = 1'b0;
        csr_ecode      = '0;
        csr_esubcode   = '0;
        csr_pc         = '0;
        csr_vaddr      = '0;
        csr_ertn_flush = 1'b0;
        csr_we         = 1'b0;
        csr_num        = '0;
        csr_wmask      = '0;
        csr_wvalue     = '0;
        flush          = 1'b0;
        flush_target   = '0;
        busy           = (state_q == ST_BLANK) & ~reset;

        unique case (state_q)
            ST_IDLE: begin
                unique case (evt)
                    EVT_INT: begin
                        csr_ex       = 1'b1;
                        csr_ecode    = ECODE_INT;
                        csr_pc       = wb_pc;
                        flush        = 1'b1;
                        flush_target = csr_eentry;
                    end
                    EVT_EXC: begin
                        csr_ex       = 1'b1;
                        csr_ecode    = wb_ecode;
                        csr_esubcode = wb_esubcode;
                        csr_pc       = wb_pc;
                        csr_vaddr    = wb_vaddr;
                        flush        = 1'b1;
                        flush_target = csr_eentry;
                    end
                    EVT_ERTN: begin
                        csr_ertn_flush = 1'b1;
                        flush          = 1'b1;
                        flush_target   = csr_era;
                    end
                    EVT_CSRW: begin
                        csr_we     = 1'b1;
                        csr_num    = wb_csr_num;
                        csr_wmask  = wb_csr_wmask;
                        csr_wvalue = wb_csr_wvalue;
                    end
                    default: ;
                endcase
                if (flush) begin
                    state_d     = ST_BLANK;
                    blank_cnt_d = BLANK_INIT;
                end
            end
            ST_BLANK: begin
                if (blank_cnt_q == '0) state_d = ST_IDLE;
                else                   blank_cnt_d = blank_cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed bench for exc_commit_ctrl: table of single-instruction commits plus hand sequences.
module tb_exc_commit_ctrl;

    localparam logic [31:0] EENTRY = 32'h1c008000;
    localparam logic [31:0] ERA    = 32'h1c000200;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, wb_ex, wb_ertn, wb_csr_we;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode, wb_csr_num;
    logic [31:0] wb_pc, wb_vaddr, wb_csr_wmask, wb_csr_wvalue;
    logic        csr_crmd_ie;
    logic [12:0] csr_ecfg_lie, csr_estat_is;
    logic [31:0] csr_eentry, csr_era;
    logic        csr_ex, csr_ertn_flush, csr_we, flush, busy;
    logic [5:0]  csr_ecode;
    logic [8:0]  csr_esubcode, csr_num;
    logic [31:0] csr_pc, csr_vaddr, csr_wmask, csr_wvalue, flush_target;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    exc_commit_ctrl #(.FLUSH_CYCLES(3), .ECODE_INT(6'h0)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .wb_ertn(wb_ertn),
        .wb_csr_we(wb_csr_we), .wb_csr_num(wb_csr_num), .wb_csr_wmask(wb_csr_wmask),
        .wb_csr_wvalue(wb_csr_wvalue),
        .csr_crmd_ie(csr_crmd_ie), .csr_ecfg_lie(csr_ecfg_lie), .csr_estat_is(csr_estat_is),
        .csr_eentry(csr_eentry), .csr_era(csr_era),
        .csr_ex(csr_ex), .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
        .csr_pc(csr_pc), .csr_vaddr(csr_vaddr), .csr_ertn_flush(csr_ertn_flush),
        .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .flush(flush), .flush_target(flush_target), .busy(busy)
    );

    typedef struct {
        logic        v, ex, ertn, we;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] pc, vaddr;
        logic [8:0]  num;
        logic [31:0] wmask, wvalue;
        logic        x_ex, x_ertn, x_we, x_flush;
        logic [31:0] x_target;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_wb();
        wb_valid = 0; wb_ex = 0; wb_ertn = 0; wb_csr_we = 0;
        wb_ecode = '0; wb_esubcode = '0; wb_pc = '0; wb_vaddr = '0;
        wb_csr_num = '0; wb_csr_wmask = '0; wb_csr_wvalue = '0;
    endtask

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, " ex"},    {31'b0, csr_ex}, 0);
        chk({nm, " ertn"},  {31'b0, csr_ertn_flush}, 0);
        chk({nm, " we"},    {31'b0, csr_we}, 0);
        chk({nm, " flush"}, {31'b0, flush}, 0);
    endtask

    task automatic exc_inputs(input logic [5:0] ec, input logic [31:0] pc);
        wb_valid = 1; wb_ex = 1; wb_ecode = ec; wb_esubcode = 9'h1; wb_pc = pc; wb_vaddr = 32'h55;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'h08, 9'h1, 32'h1c000004, 32'h1234, 9'h30, '1, 32'hdeadbeef,
                    1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 6'h08, 9'h1, 32'h1c000004, 32'h1234, 9'h30, '1, 32'hdeadbeef,
                    1'b1, 1'b0, 1'b0, 1'b1, EENTRY};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 6'h00, 9'h0, 32'h1c000040, 32'h0, 9'h30, '1, 32'h0badf00d,
                    1'b0, 1'b1, 1'b0, 1'b1, ERA};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'h00, 9'h0, 32'h1c000080, 32'h0, 9'h30, '1, 32'hdeadbeef,
                    1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'h0d, 9'h0, 32'h1c0000c0, 32'h9abc, 9'h00, '0, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b1, EENTRY};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'h00, 9'h0, 32'h1c000100, 32'h0, 9'h05, 32'h0000ffff, 32'h12345678,
                    1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h3f, 9'h1ff, 32'h1c000140, 32'hffff, 9'h1ff, '1, '1,
                    1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

        idle_wb();
        csr_crmd_ie = 0; csr_ecfg_lie = '0; csr_estat_is = '0;
        csr_eentry = EENTRY; csr_era = ERA;

        // Reset with a live exception on WB: everything must stay quiet.
        reset = 1;
        exc_inputs(6'h08, 32'h1c000004);
        next_cyc(); settle();
        chk_quiet("rst");
        chk("rst busy", {31'b0, busy}, 0);
        chk("rst target", flush_target, 0);
        next_cyc(); idle_wb(); reset = 0; settle();
        chk_quiet("post rst");
        chk("post rst busy", {31'b0, busy}, 0);

        for (int i = 0; i < 7; i++) begin
            next_cyc();
            wb_valid = vecs[i].v; wb_ex = vecs[i].ex; wb_ertn = vecs[i].ertn; wb_csr_we = vecs[i].we;
            wb_ecode = vecs[i].ecode; wb_esubcode = vecs[i].esub; wb_pc = vecs[i].pc; wb_vaddr = vecs[i].vaddr;
            wb_csr_num = vecs[i].num; wb_csr_wmask = vecs[i].wmask; wb_csr_wvalue = vecs[i].wvalue;
            settle();
            chk($sformatf("v%0d ex", i),     {31'b0, csr_ex}, {31'b0, vecs[i].x_ex});
            chk($sformatf("v%0d ecode", i),  {26'b0, csr_ecode}, vecs[i].x_ex ? {26'b0, vecs[i].ecode} : 0);
            chk($sformatf("v%0d esub", i),   {23'b0, csr_esubcode}, vecs[i].x_ex ? {23'b0, vecs[i].esub} : 0);
            chk($sformatf("v%0d pc", i),     csr_pc, vecs[i].x_ex ? vecs[i].pc : 0);
            chk($sformatf("v%0d vaddr", i),  csr_vaddr, vecs[i].x_ex ? vecs[i].vaddr : 0);
            chk($sformatf("v%0d ertn", i),   {31'b0, csr_ertn_flush}, {31'b0, vecs[i].x_ertn});
            chk($sformatf("v%0d we", i),     {31'b0, csr_we}, {31'b0, vecs[i].x_we});
            chk($sformatf("v%0d num", i),    {23'b0, csr_num}, vecs[i].x_we ? {23'b0, vecs[i].num} : 0);
            chk($sformatf("v%0d wmask", i),  csr_wmask, vecs[i].x_we ? vecs[i].wmask : 0);
            chk($sformatf("v%0d wvalue", i), csr_wvalue, vecs[i].x_we ? vecs[i].wvalue : 0);
            chk($sformatf("v%0d flush", i),  {31'b0, flush}, {31'b0, vecs[i].x_flush});
            chk($sformatf("v%0d target", i), flush_target, vecs[i].x_target);
            chk($sformatf("v%0d busy0", i),  {31'b0, busy}, 0);
            next_cyc(); idle_wb(); settle();
            chk($sformatf("v%0d busy1", i),  {31'b0, busy}, {31'b0, vecs[i].x_flush});
            repeat (3) next_cyc();
            settle();
            chk($sformatf("v%0d idle", i),   {31'b0, busy}, 0);
        end

        // Interrupt: sampled one cycle, taken on the next WB commit over a concurrent exception.
        next_cyc();
        csr_crmd_ie = 1; csr_ecfg_lie = 13'h800; csr_estat_is = 13'h800;
        settle();
        chk_quiet("int sample");
        next_cyc();
        exc_inputs(6'h08, 32'h1c000100); wb_csr_we = 1;
        settle();
        chk("int ex", {31'b0, csr_ex}, 1);
        chk("int ecode", {26'b0, csr_ecode}, 0);
        chk("int esub", {23'b0, csr_esubcode}, 0);
        chk("int pc", csr_pc, 32'h1c000100);
        chk("int vaddr", csr_vaddr, 0);
        chk("int we", {31'b0, csr_we}, 0);
        chk("int flush", {31'b0, flush}, 1);
        chk("int target", flush_target, EENTRY);
        for (int k = 1; k <= 4; k++) begin
            next_cyc(); idle_wb(); settle();
            chk($sformatf("int busy%0d", k), {31'b0, busy}, (k <= 3) ? 1 : 0);
        end
        chk_quiet("int pend no valid");
        csr_crmd_ie = 0;
        next_cyc(); next_cyc();

        // Exception held off by BLANK while WB keeps presenting an exception.
        exc_inputs(6'h08, 32'h1c000004);
        settle();
        chk("blk first ex", {31'b0, csr_ex}, 1);
        for (int k = 1; k <= 3; k++) begin
            next_cyc(); exc_inputs(6'h09, 32'h1c000008); settle();
            chk_quiet($sformatf("blk c%0d", k));
            chk($sformatf("blk c%0d busy", k), {31'b0, busy}, 1);
        end
        next_cyc(); settle();
        chk("blk end ex", {31'b0, csr_ex}, 1);
        chk("blk end ecode", {26'b0, csr_ecode}, 32'h9);
        chk("blk end busy", {31'b0, busy}, 0);

        // Interrupt raised during BLANK is taken at the first IDLE commit.
        next_cyc(); idle_wb();
        wb_valid = 1; wb_pc = 32'h1c000300;
        csr_crmd_ie = 1; csr_ecfg_lie = 13'h004; csr_estat_is = 13'h005;
        settle();
        chk_quiet("pend blank");
        next_cyc(); next_cyc(); settle();
        chk("pend still blank", {31'b0, csr_ex}, 0);
        next_cyc(); settle();
        chk("pend taken", {31'b0, csr_ex}, 1);
        chk("pend pc", csr_pc, 32'h1c000300);
        chk("pend target", flush_target, EENTRY);
        next_cyc(); idle_wb(); csr_crmd_ie = 0;
        repeat (4) next_cyc();

        // Reset in the second BLANK cycle aborts the window.
        exc_inputs(6'h0c, 32'h1c000400);
        settle();
        chk("rb flush", {31'b0, flush}, 1);
        next_cyc(); idle_wb(); settle();
        chk("rb busy1", {31'b0, busy}, 1);
        next_cyc(); reset = 1; settle();
        chk("rb busy in reset", {31'b0, busy}, 0);
        next_cyc(); reset = 0;
        wb_valid = 1; wb_csr_we = 1; wb_csr_num = 9'h30; wb_csr_wmask = '1; wb_csr_wvalue = 32'hcafef00d;
        settle();
        chk("rb busy after", {31'b0, busy}, 0);
        chk("rb we", {31'b0, csr_we}, 1);
        chk("rb wvalue", csr_wvalue, 32'hcafef00d);
        chk("rb flush after", {31'b0, flush}, 0);
        next_cyc(); idle_wb();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
